// File: rtl/fix_int_conv_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fix_int_conv_sched                                              |
// | Purpose  : Round-robin scheduler sharing one binary-to-ASCII integer       |
// |            converter among several FIX field serializers, with a watchdog  |
// |            that turns a hung conversion into an error response.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fix_int_conv_sched #(
  parameter int NUM_REQ = 4,
  parameter int BITS    = 32,
  parameter int DIGITS  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*BITS-1:0] val_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [2:0]            rsp_id_o,
  output logic [8*DIGITS-1:0]   rsp_ascii_o,
  output logic [3:0]            rsp_width_o,
  output logic [DIGITS-1:0]     rsp_size_o,
  output logic                  rsp_err_o,
  output logic                  conv_start_o,
  output logic                  conv_ce_o,
  output logic [BITS-1:0]       conv_dat_o,
  input  logic                  conv_done_i,
  input  logic [8*DIGITS-1:0]   conv_ascii_i,
  input  logic [3:0]            conv_width_i,
  input  logic [DIGITS-1:0]     conv_size_i
);

  localparam int c_WDW = $clog2(TIMEOUT + 1);
  localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);
  localparam logic [c_WDW-1:0] c_WD_FULL = c_WDW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t              r_state;
  logic [2:0]          r_rr_ptr;
  logic [2:0]          r_id;
  logic [BITS-1:0]     r_conv_dat;
  logic                r_conv_start;
  logic                r_conv_ce;
  logic                r_busy_cnt;
  logic [c_WDW-1:0]    r_wdog;
  logic                r_rsp_valid;
  logic [8*DIGITS-1:0] r_rsp_ascii;
  logic [3:0]          r_rsp_width;
  logic [DIGITS-1:0]   r_rsp_size;
  logic                r_rsp_err;

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic                 w_found;
  logic [2:0]           w_off;
  logic [3:0]           w_sum;
  logic [2:0]           w_gnt_id;
  logic [2:0]           w_rr_next;
  logic                 w_grant_en;
  logic [BITS-1:0]      w_val;

  // Rotating the doubled request vector by rr_ptr turns the circular search
  // into a plain lowest-set-bit search.
  assign w_req_dbl = {req_i, req_i} >> r_rr_ptr;

  // Find the first pending requester at or after rr_ptr and map it back to an absolute index.
  always_comb begin
    w_found = 1'b0;
    w_off   = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_dbl[i]) begin
        w_found = 1'b1;
        w_off   = 3'(i);
      end
    end
    w_sum = 4'(r_rr_ptr) + 4'(w_off);
    if (w_sum >= 4'(NUM_REQ)) begin
      w_sum = w_sum - 4'(NUM_REQ);
    end
    w_gnt_id  = w_sum[2:0];
    w_rr_next = (w_gnt_id == 3'(NUM_REQ - 1)) ? 3'd0 : w_gnt_id + 3'd1;
  end

  // A grant needs an idle scheduler and an idle converter; reset forces it low.
  assign w_grant_en = (r_state == S_IDLE) && conv_done_i && w_found && !rst_i;

  // One-hot grant and selection of the granted requester's value slice.
  always_comb begin
    gnt_o = '0;
    w_val = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_gnt_id == 3'(j)) begin
        gnt_o[j] = w_grant_en;
        w_val    = val_i[j*BITS +: BITS];
      end
    end
  end

  // Scheduler FSM: grant, start pulse, busy detection, watchdog and response hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= 3'd0;
      r_id         <= 3'd0;
      r_conv_dat   <= '0;
      r_conv_start <= 1'b0;
      r_conv_ce    <= 1'b0;
      r_busy_cnt   <= 1'b0;
      r_wdog       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_ascii  <= '0;
      r_rsp_width  <= 4'd0;
      r_rsp_size   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_en) begin
            r_conv_dat   <= w_val;
            r_id         <= w_gnt_id;
            r_rr_ptr     <= w_rr_next;
            r_conv_start <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // ce is raised together with the drop of start so the converter
          // is already enabled on its first busy cycle.
          r_conv_start <= 1'b0;
          r_conv_ce    <= 1'b1;
          r_busy_cnt   <= 1'b0;
          r_state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!conv_done_i) begin
            r_wdog  <= '0;
            r_state <= S_WAIT_DONE;
          end else if (r_busy_cnt) begin
            // Converter never acknowledged the start: report an error.
            r_conv_ce   <= 1'b0;
            r_rsp_ascii <= '0;
            r_rsp_width <= 4'd0;
            r_rsp_size  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_busy_cnt <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (conv_done_i) begin
            r_conv_ce   <= 1'b0;
            r_rsp_ascii <= conv_ascii_i;
            r_rsp_width <= conv_width_i;
            r_rsp_size  <= conv_size_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_wdog == c_WD_LAST) begin
            r_wdog      <= c_WD_FULL;
            r_conv_ce   <= 1'b0;
            r_rsp_ascii <= '0;
            r_rsp_width <= 4'd0;
            r_rsp_size  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wdog <= r_wdog + c_WDW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_wdog      <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_id_o     = r_id;
  assign rsp_ascii_o  = r_rsp_ascii;
  assign rsp_width_o  = r_rsp_width;
  assign rsp_size_o   = r_rsp_size;
  assign rsp_err_o    = r_rsp_err;
  assign conv_start_o = r_conv_start;
  assign conv_ce_o    = r_conv_ce;
  assign conv_dat_o   = r_conv_dat;

endmodule
`default_nettype wire

// File: tb/tb_fix_int_conv_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fix_int_conv_sched                                           |
// | Purpose  : Directed self-checking bench for fix_int_conv_sched with a      |
// |            behavioural converter stub (normal / hung / never-busy modes).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fix_int_conv_sched;

  localparam int NUM_REQ = 4;
  localparam int BITS    = 32;
  localparam int DIGITS  = 10;
  localparam int TIMEOUT = 64;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [NUM_REQ-1:0]      req_i;
  logic [NUM_REQ*BITS-1:0] val_i;
  logic [NUM_REQ-1:0]      gnt_o;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [2:0]              rsp_id_o;
  logic [8*DIGITS-1:0]     rsp_ascii_o;
  logic [3:0]              rsp_width_o;
  logic [DIGITS-1:0]       rsp_size_o;
  logic                    rsp_err_o;
  logic                    conv_start_o;
  logic                    conv_ce_o;
  logic [BITS-1:0]         conv_dat_o;
  logic                    conv_done_i;
  logic [8*DIGITS-1:0]     conv_ascii_i;
  logic [3:0]              conv_width_i;
  logic [DIGITS-1:0]       conv_size_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mode = 0;  // 0 normal, 1 hung (busy forever), 2 never leaves done

  fix_int_conv_sched #(
    .NUM_REQ(NUM_REQ), .BITS(BITS), .DIGITS(DIGITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .val_i(val_i), .gnt_o(gnt_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_ascii_o(rsp_ascii_o), .rsp_width_o(rsp_width_o), .rsp_size_o(rsp_size_o),
    .rsp_err_o(rsp_err_o), .conv_start_o(conv_start_o), .conv_ce_o(conv_ce_o),
    .conv_dat_o(conv_dat_o), .conv_done_i(conv_done_i), .conv_ascii_i(conv_ascii_i),
    .conv_width_i(conv_width_i), .conv_size_i(conv_size_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Converter stub: busy for BITS cycles after the start pulse.
  int          stub_cnt;
  logic [31:0] stub_val;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stub_cnt <= 0;
      stub_val <= '0;
    end else if (conv_start_o && stub_cnt == 0 && mode != 2) begin
      stub_cnt <= BITS;
      stub_val <= conv_dat_o;
    end else if (stub_cnt > 0 && mode != 1) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign conv_done_i = (stub_cnt == 0);

  logic [31:0] sv_v;
  int          sv_w;
  always_comb begin
    sv_v         = stub_val;
    sv_w         = 0;
    conv_ascii_i = '0;
    for (int d = 0; d < DIGITS; d++) begin
      conv_ascii_i[d*8 +: 8] = 8'h30 + 8'(sv_v % 32'd10);
      if (sv_v != 0) sv_w = sv_w + 1;
      sv_v = sv_v / 32'd10;
    end
    conv_width_i = 4'(sv_w);
    conv_size_i  = DIGITS'((1 << sv_w) - 1);
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    req_i = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_gnt(input string tag, input logic [3:0] exp, input bit drop,
                          output int gcyc);
    int c;
    c = 0;
    #1;
    while (gnt_o == '0 && c < 100) begin
      @(negedge clk_i);
      #1;
      c++;
    end
    check(tag, 80'(gnt_o), 80'(exp));
    gcyc = cyc;
    @(posedge clk_i);
    #1;
    if (drop) req_i = req_i & ~exp;
  endtask

  task automatic wait_rsp(input string tag, output int rcyc);
    int c;
    c = 0;
    while (!rsp_valid_o && c < 200) begin
      @(negedge clk_i);
      c++;
    end
    check(tag, 80'(rsp_valid_o), 80'd1);
    rcyc = cyc;
  endtask

  logic [3:0]  t2_gnt [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0]  t2_wid [4] = '{4'd0, 4'd1, 4'd10, 4'd4};
  logic [9:0]  t2_siz [4] = '{10'h000, 10'h001, 10'h3FF, 10'h00F};
  logic [7:0]  t2_d0  [4] = '{8'h30, 8'h39, 8'h35, 8'h30};
  logic [3:0]  t3_gnt [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

  initial begin
    int g, r, pg, bad;
    logic [79:0] snap;
    rst_i = 1'b1; req_i = '0; val_i = '0; rsp_ready_i = 1'b0;

    // Reset state, with a request pending to show gnt is held low.
    req_i = 4'b0001;
    #1;
    check("rst_outs", 80'({gnt_o, rsp_valid_o, rsp_id_o, rsp_width_o, rsp_size_o, rsp_err_o,
                           conv_start_o, conv_ce_o, conv_dat_o}), 80'd0);
    check("rst_ascii", rsp_ascii_o, 80'd0);
    req_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Single request, value 12345.
    rsp_ready_i = 1'b1;
    val_i[31:0] = 32'd12345;
    req_i = 4'b0001;
    wait_gnt("t1_gnt", 4'b0001, 1'b0, g);
    check("t1_gnt_pulse", 80'(gnt_o), 80'd0);
    check("t1_start", 80'(conv_start_o), 80'd1);
    check("t1_dat", 80'(conv_dat_o), 80'd12345);
    req_i = '0;
    @(posedge clk_i); #1;
    check("t1_start_drop", 80'(conv_start_o), 80'd0);
    wait_rsp("t1_valid", r);
    check("t1_lat", 80'(r - g), 80'd35);
    check("t1_ascii", 80'(rsp_ascii_o[39:0]), 80'h3132333435);
    check("t1_width", 80'(rsp_width_o), 80'd5);
    check("t1_size", 80'(rsp_size_o), 80'h01F);
    check("t1_id", 80'(rsp_id_o), 80'd0);
    check("t1_err", 80'(rsp_err_o), 80'd0);
    check("t1_dat_hold", 80'(conv_dat_o), 80'd12345);

    // All four at once, ready high: grants 0..3 back to back.
    do_reset();
    val_i = {32'd1000, 32'hFFFF_FFFF, 32'd9, 32'd0};
    req_i = 4'b1111;
    pg = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt($sformatf("t2_gnt%0d", k), t2_gnt[k], 1'b1, g);
      if (k > 0) check($sformatf("t2_gap%0d", k), 80'(g - pg), 80'd36);
      pg = g;
      wait_rsp($sformatf("t2_valid%0d", k), r);
      check($sformatf("t2_id%0d", k), 80'(rsp_id_o), 80'(k));
      check($sformatf("t2_width%0d", k), 80'(rsp_width_o), 80'(t2_wid[k]));
      check($sformatf("t2_size%0d", k), 80'(rsp_size_o), 80'(t2_siz[k]));
      check($sformatf("t2_d0_%0d", k), 80'(rsp_ascii_o[7:0]), 80'(t2_d0[k]));
      if (k == 2) check("t2_ascii_max", rsp_ascii_o, 80'h34323934393637323935);
    end

    // Fairness: requesters 0 and 2 held continuously.
    do_reset();
    val_i = {32'd0, 32'd22, 32'd0, 32'd11};
    req_i = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_gnt($sformatf("t3_gnt%0d", k), t3_gnt[k], 1'b0, g);
      wait_rsp($sformatf("t3_valid%0d", k), r);
      check($sformatf("t3_id%0d", k), 80'(rsp_id_o), (k % 2 == 0) ? 80'd0 : 80'd2);
      if (k == 3) req_i = '0;
    end

    // Back-pressure: ready low for 20 cycles.
    do_reset();
    rsp_ready_i = 1'b0;
    val_i = {32'd0, 32'd0, 32'd77, 32'd5};
    req_i = 4'b0010;
    wait_gnt("t4_gnt", 4'b0010, 1'b1, g);
    wait_rsp("t4_valid", r);
    snap = rsp_ascii_o;
    req_i = 4'b0001;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i); #1;
      if (!rsp_valid_o || rsp_ascii_o !== snap || gnt_o != '0) bad++;
    end
    check("t4_stable", 80'(bad), 80'd0);
    check("t4_width", 80'(rsp_width_o), 80'd2);
    check("t4_ascii", 80'(rsp_ascii_o[15:0]), 80'h3737);
    rsp_ready_i = 1'b1;
    @(negedge clk_i); #1;
    check("t4_next_gnt", 80'(gnt_o), 80'b0001);
    @(posedge clk_i); #1;
    req_i = '0;
    wait_rsp("t4_valid2", r);
    check("t4_d0", 80'(rsp_ascii_o[7:0]), 80'h35);

    // Hung converter: busy forever -> watchdog error.
    do_reset();
    mode = 1;
    val_i[31:0] = 32'd4321;
    req_i = 4'b0001;
    wait_gnt("t5_gnt", 4'b0001, 1'b1, g);
    wait_rsp("t5_valid", r);
    check("t5_lat", 80'(r - g), 80'(TIMEOUT + 3));
    check("t5_err", 80'(rsp_err_o), 80'd1);
    check("t5_ascii", rsp_ascii_o, 80'd0);
    check("t5_wsz", 80'({rsp_width_o, rsp_size_o}), 80'd0);

    // Converter that never goes busy -> error after two WAIT_BUSY cycles.
    do_reset();
    mode = 2;
    req_i = 4'b0001;
    wait_gnt("t5b_gnt", 4'b0001, 1'b1, g);
    wait_rsp("t5b_valid", r);
    check("t5b_lat", 80'(r - g), 80'd4);
    check("t5b_err", 80'(rsp_err_o), 80'd1);
    check("t5b_ascii", rsp_ascii_o, 80'd0);

    // Asynchronous reset in the middle of WAIT_DONE.
    do_reset();
    mode = 0;
    val_i[95:64] = 32'd555;
    req_i = 4'b0100;
    wait_gnt("t6_gnt", 4'b0100, 1'b1, g);
    repeat (10) @(negedge clk_i);
    req_i = 4'b1010;
    #1;
    check("t6_ce_before", 80'(conv_ce_o), 80'd1);
    rst_i = 1'b1;
    #1;
    check("t6_rst_outs", 80'({gnt_o, rsp_valid_o, rsp_id_o, rsp_width_o, rsp_size_o, rsp_err_o,
                              conv_start_o, conv_ce_o, conv_dat_o}), 80'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("t6_gnt_after", 80'(gnt_o), 80'b0010);
    @(posedge clk_i); #1;
    req_i = '0;
    repeat (2) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fix_int_conv_sched.md
# fix_int_conv_sched

Round-robin scheduler that shares one binary-to-BCD/ASCII integer converter among several FIX field serializers (e.g. MsgSeqNum, BodyLength, OrderQty, Price-integer writers). It accepts binary values from up to NUM_REQ requesters and sequences the converter's start/ce/done handshake. It captures the ASCII digits, width and size mask, then returns them to the originating requester tagged with its ID. It also provides a watchdog so a hung conversion cannot stall the encoder pipeline.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- BITS, 32, binary value width; must equal converter BITS_IN_PP
- DIGITS, 10, BCD digit count; must equal converter BCD_DIGITS_OUT_PP
- TIMEOUT, 64, max cycles in WAIT_DONE before error (≥ BITS+2)

- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous and active-high
- req_i  in  NUM_REQ  per-requester request, held until granted
- val_i  in  NUM_REQ*BITS  per-requester binary value, slice k = [k*BITS +: BITS]
- gnt_o  out  NUM_REQ  one-hot, one-cycle grant; value of granted slice sampled this cycle
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted when valid&ready
- rsp_id_o  out  3  index of requester owning response
- rsp_ascii_o  out  8*DIGITS  ASCII digits, digit 0 (LS) in bits [7:0]
- rsp_width_o  out  4  significant digit count (0 for value 0)
- rsp_size_o  out  DIGITS  thermometer byte mask
- rsp_err_o  out  1  conversion timed out; ascii/width/size forced to 0
- conv_start_o  out  1  converter start
- conv_ce_o  out  1  converter clock enable
- conv_dat_o  out  BITS  converter binary input
- conv_done_i  in  1  converter idle/done (high when not busy)
- conv_ascii_i, conv_width_i, conv_size_i  in  8*DIGITS/4/DIGITS  converter result

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if any req_i set and conv_done_i=1, grant the first requester at or after rr_ptr (circular search), pulse gnt_o, latch val slice into conv_dat_o and ID into id_reg, set rr_ptr = granted+1 mod NUM_REQ, go ISSUE. If conv_done_i=0 in IDLE, no grant.
- ISSUE: conv_start_o=1 for exactly one cycle; go WAIT_BUSY.
- WAIT_BUSY: conv_start_o=0. conv_done_i=0 -> WAIT_DONE. If conv_done_i is still 1 after 2 cycles in this state -> RESP with err.
- WAIT_DONE: conv_ce_o=1. Watchdog counts from 0. conv_done_i=1 -> capture conv_ascii_i/width/size into response regs, err=0, go RESP. Watchdog reaching TIMEOUT -> zero the response data, err=1, go RESP.
- RESP: rsp_valid_o=1 with stable data; on rsp_ready_i=1 go IDLE. No new grant while in RESP (single outstanding conversion).
- conv_start_o is never high in WAIT_DONE. The converter ignores completion while start is high.
- conv_dat_o holds the latched value from grant until the next grant.
- Requester dropping req_i before grant: allowed, no grant issued. Requests arriving in any non-IDLE state wait.
- Reset (any time, including mid-conversion): state IDLE, rr_ptr=0, every output 0, watchdog 0. The converter shares rst_i.

## Timing
- Grant cycle = G. conv_start_o high at G+1. Converter busy (done=0) G+2..G+1+BITS. Capture at G+2+BITS. rsp_valid_o first high at G+3+BITS (35 cycles for BITS=32).
- The FSM keys off conv_done_i edges, never off a fixed count.
- With rsp_ready_i held high, the next grant can occur the cycle after the response handshake: back-to-back throughput is one conversion per BITS+4 cycles.
- gnt_o is combinational from state/req_i/rr_ptr. All other outputs are registered.
- Watchdog timeout: rsp_valid_o at the cycle after the counter reaches TIMEOUT.

## Test plan
- Single request: req_i=0001, val=12345 -> gnt_o=0001 one cycle. rsp_valid at G+35, ascii LS bytes "54321" (0x35,0x34,0x33,0x32,0x31), width=5, size=0x01F, id=0, err=0.
- All four request simultaneously, ready held high, values 0, 9, 4294967295, 1000 -> grants in order 0,1,2,3. Widths 0, 1, 10, 4. Value 0 gives size=0, ascii digit0=0x30.
- Fairness: req 0 and 2 continuously asserted -> grants alternate 0,2,0,2. Never two consecutive grants to the same requester.
- Back-pressure: rsp_ready_i low for 20 cycles -> rsp_valid and data stable, no gnt_o pulse. After ready, next grant on the following cycle.
- Hung converter: stub holds conv_done_i=0 forever -> after TIMEOUT cycles rsp_valid=1, err=1, ascii=0. Also stub never drops done -> err after 2 WAIT_BUSY cycles.
- Reset asserted mid-WAIT_DONE -> all outputs 0 immediately (async). After release, a pending req_i is granted with rr_ptr=0 priority.
